// File: rtl/bus_stim_pkg.sv
// Shared definitions for the bus stimulus/memory model.
//   state_e    : LOAD (preload RAM, CPU held in reset), RUN (CPU live), HALT
//                (CPU held in reset after a sentinel write).
//   VEC_*      : the six fixed vector-byte addresses at the top of memory.
//   in_window  : true when addr falls in [base, base + 2**aw).
package bus_stim_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [15:0] VEC_NMI_LO = 16'hFFFA;
  localparam logic [15:0] VEC_NMI_HI = 16'hFFFB;
  localparam logic [15:0] VEC_RST_LO = 16'hFFFC;
  localparam logic [15:0] VEC_RST_HI = 16'hFFFD;
  localparam logic [15:0] VEC_IRQ_LO = 16'hFFFE;
  localparam logic [15:0] VEC_IRQ_HI = 16'hFFFF;

  // A 17-bit offset keeps the window test exact even for a window that ends
  // right below the vector bytes.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input int unsigned aw);
    logic [16:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (off < (17'd1 << aw));
  endfunction

endpackage

// File: rtl/bus_stim_memory_irq_pulse_scheduler.sv
// One programmable interrupt pulse source.
//   clk, nrst       : clock, synchronous active-low reset.
//   i_run           : high while the CPU is running; requests only fire then.
//   i_sched_valid   : arm (or re-arm) with target i_sched_cycle.
//   i_sched_cycle   : target value of the run-cycle counter.
//   i_cycle_count   : current run-cycle counter.
//   o_req           : request, high for IRQ_HOLD cycles starting at the
//                     cycle whose count equals the target.
module irq_pulse_scheduler #(
  parameter int unsigned IRQ_HOLD = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_run,
  input  logic        i_sched_valid,
  input  logic [15:0] i_sched_cycle,
  input  logic [15:0] i_cycle_count,
  output logic        o_req
);

  localparam logic [15:0] HOLD_M1 = 16'(IRQ_HOLD - 1);

  logic        r_armed;
  logic [15:0] r_target;
  logic [15:0] r_hold;
  logic        w_fire;

  // Equality compare only: a target the counter has already passed is
  // never matched again, so it simply stays armed and silent.
  assign w_fire = r_armed & i_run & (i_cycle_count == r_target);

  // The first request cycle comes straight from the compare; r_hold covers
  // the remaining IRQ_HOLD-1 cycles.
  assign o_req = i_run & (w_fire | (r_hold != 16'd0));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_armed  <= 1'b0;
      r_target <= 16'd0;
      r_hold   <= 16'd0;
    end else begin
      if (i_sched_valid) begin
        r_armed  <= 1'b1;
        r_target <= i_sched_cycle;
      end else if (w_fire) begin
        r_armed <= 1'b0;
      end

      if (!i_run) begin
        r_hold <= 16'd0;
      end else if (w_fire) begin
        r_hold <= HOLD_M1;
      end else if (r_hold != 16'd0) begin
        r_hold <= r_hold - 16'd1;
      end
    end
  end

endmodule

// File: rtl/bus_stim_memory.sv
// Bus-side stimulus and memory model for CPU benches.
// Serves CPU reads from a preloadable RAM window plus fixed vector bytes,
// captures CPU writes, drives the CPU reset, injects scheduled NMI/IRQ
// requests and halts on a write to a sentinel address.
//   clk, nrst                         : clock, synchronous active-low reset.
//   AddressBusHigh/Low                : CPU address.
//   dataBusOutput, cpu_write          : CPU write data and strobe.
//   dataBusInput                      : read data to the CPU.
//   load_valid/addr/data, load_ready  : RAM preload port (LOAD only).
//   go                                : LOAD -> RUN.
//   irq/nmi_sched_valid/cycle         : interrupt schedules.
//   cpu_nrst                          : CPU reset, high only in RUN.
//   nonMaskableInterrupt, interruptRequest : interrupt requests.
//   cycle_count                       : RUN cycles elapsed, saturating.
//   wr_seen, wr_addr, wr_data         : captured CPU write.
//   halted                            : high in HALT.
//   dbg_state                         : FSM state (state_e encoding).
module bus_stim_memory
  import bus_stim_pkg::*;
#(
  parameter int          MEM_AW       = 10,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter logic [7:0]  DEFAULT_DATA = 8'hEA,
  parameter logic [15:0] RESET_VEC    = 16'hCCDD,
  parameter logic [15:0] NMI_VEC      = 16'h0200,
  parameter logic [15:0] IRQ_VEC      = 16'h0300,
  parameter logic [15:0] HALT_ADDR    = 16'h00FF,
  parameter int          READ_LATENCY = 0,
  parameter int unsigned IRQ_HOLD     = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  AddressBusHigh,
  input  logic [7:0]  AddressBusLow,
  input  logic [7:0]  dataBusOutput,
  input  logic        cpu_write,
  output logic [7:0]  dataBusInput,
  input  logic        load_valid,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  input  logic        go,
  input  logic        irq_sched_valid,
  input  logic [15:0] irq_sched_cycle,
  input  logic        nmi_sched_valid,
  input  logic [15:0] nmi_sched_cycle,
  output logic        cpu_nrst,
  output logic        nonMaskableInterrupt,
  output logic        interruptRequest,
  output logic [15:0] cycle_count,
  output logic        wr_seen,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  localparam int MEM_DEPTH = 2 ** MEM_AW;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_cpu_nrst;
  logic        r_halted;
  logic        r_load_ready;
  logic [15:0] r_count;
  logic        r_wr_seen;
  logic [15:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic [7:0]  r_mem [MEM_DEPTH];

  logic [15:0]       w_addr;
  logic              w_run;
  logic              w_addr_in_win;
  logic              w_load_in_win;
  logic [MEM_AW-1:0] w_rd_idx;
  logic [MEM_AW-1:0] w_ld_idx;
  logic              w_cpu_wr;
  logic              w_load_wr;
  logic [7:0]        w_rd_data;

  assign w_addr        = {AddressBusHigh, AddressBusLow};
  assign w_run         = (r_state == ST_RUN);
  assign w_addr_in_win = in_window(w_addr, BASE_ADDR, MEM_AW);
  assign w_load_in_win = in_window(load_addr, BASE_ADDR, MEM_AW);
  assign w_rd_idx      = MEM_AW'(w_addr - BASE_ADDR);
  assign w_ld_idx      = MEM_AW'(load_addr - BASE_ADDR);

  // Preload handshake: a beat transfers on a posedge where load_valid and
  // load_ready are both high. load_ready is high for exactly the LOAD state,
  // so beats outside LOAD are ignored; beats outside the window are accepted
  // and dropped.
  assign w_load_wr = load_valid & r_load_ready & w_load_in_win;

  // CPU writes are only captured while the CPU is out of reset.
  assign w_cpu_wr  = w_run & cpu_write;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (go) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_cpu_wr && (w_addr == HALT_ADDR)) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // RAM has no reset so an image survives nrst.
  always_ff @(posedge clk) begin
    if (w_load_wr) begin
      r_mem[w_ld_idx] <= load_data;
    end else if (w_cpu_wr && w_addr_in_win) begin
      r_mem[w_rd_idx] <= dataBusOutput;
    end
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= ST_LOAD;
      r_cpu_nrst   <= 1'b0;
      r_halted     <= 1'b0;
      r_load_ready <= 1'b1;
      r_count      <= 16'd0;
      r_wr_seen    <= 1'b0;
      r_wr_addr    <= 16'd0;
      r_wr_data    <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cpu_nrst   <= (w_state_nxt == ST_RUN);
      r_halted     <= (w_state_nxt == ST_HALT);
      r_load_ready <= (w_state_nxt == ST_LOAD);
      if (w_run && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
      r_wr_seen <= w_cpu_wr;
      if (w_cpu_wr) begin
        r_wr_addr <= w_addr;
        r_wr_data <= dataBusOutput;
      end
    end
  end

  // Read decode: vector bytes win over the RAM window, anything else reads
  // the default byte. The array read sees pre-edge contents, so a read in
  // the same cycle as a write to that address returns the old byte.
  always_comb begin
    w_rd_data = DEFAULT_DATA;
    case (w_addr)
      VEC_NMI_LO: w_rd_data = NMI_VEC[7:0];
      VEC_NMI_HI: w_rd_data = NMI_VEC[15:8];
      VEC_RST_LO: w_rd_data = RESET_VEC[7:0];
      VEC_RST_HI: w_rd_data = RESET_VEC[15:8];
      VEC_IRQ_LO: w_rd_data = IRQ_VEC[7:0];
      VEC_IRQ_HI: w_rd_data = IRQ_VEC[15:8];
      default:    if (w_addr_in_win) w_rd_data = r_mem[w_rd_idx];
    endcase
  end

  generate
    if (READ_LATENCY == 1) begin : g_rd_reg
      logic [7:0] r_rd_data;
      always_ff @(posedge clk) begin
        if (!nrst) begin
          r_rd_data <= DEFAULT_DATA;
        end else begin
          r_rd_data <= w_rd_data;
        end
      end
      assign dataBusInput = r_rd_data;
    end else begin : g_rd_comb
      assign dataBusInput = w_rd_data;
    end
  endgenerate

  irq_pulse_scheduler #(.IRQ_HOLD(IRQ_HOLD)) u_nmi_sched (
    .clk           (clk),
    .nrst          (nrst),
    .i_run         (w_run),
    .i_sched_valid (nmi_sched_valid),
    .i_sched_cycle (nmi_sched_cycle),
    .i_cycle_count (r_count),
    .o_req         (nonMaskableInterrupt)
  );

  irq_pulse_scheduler #(.IRQ_HOLD(IRQ_HOLD)) u_irq_sched (
    .clk           (clk),
    .nrst          (nrst),
    .i_run         (w_run),
    .i_sched_valid (irq_sched_valid),
    .i_sched_cycle (irq_sched_cycle),
    .i_cycle_count (r_count),
    .o_req         (interruptRequest)
  );

  assign load_ready  = r_load_ready;
  assign cpu_nrst    = r_cpu_nrst;
  assign halted      = r_halted;
  assign cycle_count = r_count;
  assign wr_seen     = r_wr_seen;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_bus_stim_memory.sv
module tb_bus_stim_memory;

  localparam int HOLD   = 2;
  localparam int MSZ    = 1024;
  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        cpu_write;
  logic        load_valid;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  logic        go;
  logic        irq_sv;
  logic [15:0] irq_sc;
  logic        nmi_sv;
  logic [15:0] nmi_sc;

  logic [7:0]  d0_data, d1_data;
  logic        d0_load_ready, d1_load_ready;
  logic        d0_cpu_nrst, d1_cpu_nrst;
  logic        d0_nmi, d1_nmi;
  logic        d0_irq, d1_irq;
  logic [15:0] d0_count, d1_count;
  logic        d0_wr_seen, d1_wr_seen;
  logic [15:0] d0_wr_addr, d1_wr_addr;
  logic [7:0]  d0_wr_data, d1_wr_data;
  logic        d0_halted, d1_halted;
  logic [1:0]  d0_dbg, d1_dbg;

  bus_stim_memory #(.READ_LATENCY(0), .IRQ_HOLD(HOLD)) dut0 (
    .clk(clk), .nrst(nrst),
    .AddressBusHigh(addr[15:8]), .AddressBusLow(addr[7:0]),
    .dataBusOutput(wdata), .cpu_write(cpu_write), .dataBusInput(d0_data),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(d0_load_ready), .go(go),
    .irq_sched_valid(irq_sv), .irq_sched_cycle(irq_sc),
    .nmi_sched_valid(nmi_sv), .nmi_sched_cycle(nmi_sc),
    .cpu_nrst(d0_cpu_nrst), .nonMaskableInterrupt(d0_nmi), .interruptRequest(d0_irq),
    .cycle_count(d0_count), .wr_seen(d0_wr_seen), .wr_addr(d0_wr_addr),
    .wr_data(d0_wr_data), .halted(d0_halted), .dbg_state(d0_dbg)
  );

  bus_stim_memory #(.READ_LATENCY(1), .IRQ_HOLD(HOLD)) dut1 (
    .clk(clk), .nrst(nrst),
    .AddressBusHigh(addr[15:8]), .AddressBusLow(addr[7:0]),
    .dataBusOutput(wdata), .cpu_write(cpu_write), .dataBusInput(d1_data),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(d1_load_ready), .go(go),
    .irq_sched_valid(irq_sv), .irq_sched_cycle(irq_sc),
    .nmi_sched_valid(nmi_sv), .nmi_sched_cycle(nmi_sc),
    .cpu_nrst(d1_cpu_nrst), .nonMaskableInterrupt(d1_nmi), .interruptRequest(d1_irq),
    .cycle_count(d1_count), .wr_seen(d1_wr_seen), .wr_addr(d1_wr_addr),
    .wr_data(d1_wr_data), .halted(d1_halted), .dbg_state(d1_dbg)
  );

  // ---------------- reference model ----------------
  logic [7:0]  m_mem [MSZ];
  bit          m_known [MSZ];
  int          m_mode;
  int          m_count;
  logic        m_wr_seen;
  logic [15:0] m_wr_addr;
  logic [7:0]  m_wr_data;
  logic [7:0]  m_rd_reg;
  bit          m_rd_known;
  int          irq_t, nmi_t, irq_fire, nmi_fire;
  bit          irq_armed, nmi_armed;

  int checks = 0;
  int errors = 0;

  // {known, byte} that the bus should return for address a.
  function automatic logic [8:0] model_read(input logic [15:0] a);
    case (a)
      16'hFFFA: return {1'b1, 8'h00};
      16'hFFFB: return {1'b1, 8'h02};
      16'hFFFC: return {1'b1, 8'hDD};
      16'hFFFD: return {1'b1, 8'hCC};
      16'hFFFE: return {1'b1, 8'h00};
      16'hFFFF: return {1'b1, 8'h03};
      default: begin
        if (a < 16'(MSZ)) return {m_known[a[9:0]], m_mem[a[9:0]]};
        return {1'b1, 8'hEA};
      end
    endcase
  endfunction

  // Request is high at the target cycle itself and for HOLD cycles from the
  // most recent firing.
  function automatic logic exp_req(input bit armed, input int t, input int fire);
    if (m_mode != M_RUN) return 1'b0;
    if (armed && (m_count == t)) return 1'b1;
    return (fire >= 0) && (m_count >= fire) && (m_count < fire + HOLD);
  endfunction

  task automatic model_reset();
    m_mode = M_LOAD; m_count = 0;
    m_wr_seen = 1'b0; m_wr_addr = 16'd0; m_wr_data = 8'd0;
    m_rd_reg = 8'hEA; m_rd_known = 1'b1;
    irq_armed = 1'b0; nmi_armed = 1'b0; irq_fire = -1; nmi_fire = -1;
    irq_t = 0; nmi_t = 0;
  endtask

  task automatic model_edge();
    logic [8:0] r;
    if (!nrst) begin
      model_reset();
      return;
    end
    r = model_read(addr);
    m_rd_reg = r[7:0];
    m_rd_known = r[8];
    if (m_mode == M_LOAD) begin
      m_wr_seen = 1'b0;
      if (load_valid && (load_addr < 16'(MSZ))) begin
        m_mem[load_addr[9:0]] = load_data;
        m_known[load_addr[9:0]] = 1'b1;
      end
      if (go) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (irq_armed && (m_count == irq_t)) begin irq_fire = irq_t; irq_armed = 1'b0; end
      if (nmi_armed && (m_count == nmi_t)) begin nmi_fire = nmi_t; nmi_armed = 1'b0; end
      m_wr_seen = cpu_write;
      if (cpu_write) begin
        m_wr_addr = addr;
        m_wr_data = wdata;
        if (addr < 16'(MSZ)) begin
          m_mem[addr[9:0]] = wdata;
          m_known[addr[9:0]] = 1'b1;
        end
        if (addr == 16'h00FF) m_mode = M_HALT;
      end
      if (m_count < 65535) m_count++;
    end else begin
      m_wr_seen = 1'b0;
    end
    if (irq_sv) begin irq_armed = 1'b1; irq_t = int'(irq_sc); end
    if (nmi_sv) begin nmi_armed = 1'b1; nmi_t = int'(nmi_sc); end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [8:0] r;
    r = model_read(addr);
    if (r[8]) chk8({ph, ":rd0"}, d0_data, r[7:0]);
    if (m_rd_known) chk8({ph, ":rd1"}, d1_data, m_rd_reg);
    chk1 ({ph, ":load_ready"}, d0_load_ready, m_mode == M_LOAD);
    chk1 ({ph, ":cpu_nrst"},   d0_cpu_nrst,   m_mode == M_RUN);
    chk1 ({ph, ":halted"},     d0_halted,     m_mode == M_HALT);
    chk16({ph, ":count"},      d0_count,      16'(m_count));
    chk1 ({ph, ":wr_seen"},    d0_wr_seen,    m_wr_seen);
    chk16({ph, ":wr_addr"},    d0_wr_addr,    m_wr_addr);
    chk8 ({ph, ":wr_data"},    d0_wr_data,    m_wr_data);
    chk1 ({ph, ":irq"},        d0_irq,        exp_req(irq_armed, irq_t, irq_fire));
    chk1 ({ph, ":nmi"},        d0_nmi,        exp_req(nmi_armed, nmi_t, nmi_fire));
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with inputs set; checks at posedge+2, then clocks.
  task automatic step(input string ph);
    #1;
    check_all(ph);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cpu_write = 1'b0; load_valid = 1'b0; go = 1'b0;
    irq_sv = 1'b0; nmi_sv = 1'b0; wdata = 8'd0;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFA + 16'($urandom_range(0, 5));
      1, 2:    return 16'($urandom_range(0, MSZ - 1));
      default: return 16'($urandom_range(MSZ, 16'hFFF9));
    endcase
  endfunction

  task automatic check_reset_outputs(input string ph);
    chk1 ({ph, ":load_ready"}, d0_load_ready, 1'b1);
    chk1 ({ph, ":cpu_nrst"},   d0_cpu_nrst,   1'b0);
    chk16({ph, ":count"},      d0_count,      16'd0);
    chk1 ({ph, ":halted"},     d0_halted,     1'b0);
    chk1 ({ph, ":wr_seen"},    d0_wr_seen,    1'b0);
    chk16({ph, ":wr_addr"},    d0_wr_addr,    16'd0);
    chk8 ({ph, ":wr_data"},    d0_wr_data,    8'd0);
    chk1 ({ph, ":irq"},        d0_irq,        1'b0);
    chk1 ({ph, ":nmi"},        d0_nmi,        1'b0);
    chk8 ({ph, ":rd1_reset"},  d1_data,       8'hEA);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < MSZ; i++) begin m_known[i] = 1'b0; m_mem[i] = 8'd0; end
    model_reset();
    nrst = 1'b0; set_idle();
    addr = 16'hFFFC; load_addr = 16'd0; load_data = 8'd0;
    irq_sc = 16'd0; nmi_sc = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;

    // Preload the whole window, with a few dropped out-of-window beats.
    for (int i = 0; i < MSZ - 1; i++) begin
      load_valid = 1'b1;
      load_addr  = 16'(i);
      load_data  = (i == 0) ? 8'hCD : (i == 1) ? 8'h34 : (i == 16) ? 8'hA5 : 8'($urandom);
      addr       = rand_addr();
      step("load");
      if ((i % 256) == 100) begin
        load_addr = 16'h4000 + 16'(i);
        load_data = 8'($urandom);
        addr      = 16'h4000 + 16'(i);
        step("load_oow");
      end
    end
    // Last load shares its cycle with go.
    load_addr = 16'h03FF; load_data = 8'($urandom); go = 1'b1; addr = 16'hFFFC;
    step("go");
    set_idle();

    addr = 16'hFFFC; #1;
    chk8("vec_fffc", d0_data, 8'hDD);
    chk1("load_ready_after_go", d0_load_ready, 1'b0);
    chk1("cpu_nrst_after_go", d0_cpu_nrst, 1'b1);
    step("vec");
    addr = 16'hFFFD; #1;
    chk8("vec_fffd", d0_data, 8'hCC);
    chk8("lat1_fffc", d1_data, 8'hDD);
    step("vec");
    addr = 16'hFFFA; #1;
    chk8("vec_fffa", d0_data, 8'h00);
    chk8("lat1_fffd", d1_data, 8'hCC);
    step("vec");
    addr = 16'hFFFF; #1;
    chk8("vec_ffff", d0_data, 8'h03);
    step("vec");
    addr = 16'h0001; #1;
    chk8("pre_0001", d0_data, 8'h34);
    step("pre");
    addr = 16'h4000; #1;
    chk8("unmapped_4000", d0_data, 8'hEA);
    chk8("lat1_0001", d1_data, 8'h34);
    step("pre");

    // CPU write with a same-cycle read of the same address.
    addr = 16'h0010; cpu_write = 1'b1; wdata = 8'h5A; #1;
    chk8("rdw_old", d0_data, 8'hA5);
    step("wr");
    cpu_write = 1'b0; #1;
    chk1 ("wr_seen_pulse", d0_wr_seen, 1'b1);
    chk16("wr_addr", d0_wr_addr, 16'h0010);
    chk8 ("wr_data", d0_wr_data, 8'h5A);
    chk8 ("rd_after_wr", d0_data, 8'h5A);
    chk8 ("lat1_rdw_old", d1_data, 8'hA5);
    step("wr");
    #1;
    chk1("wr_seen_one_cycle", d0_wr_seen, 1'b0);
    step("wr");

    // Randomized run against the model; low addresses and HALT_ADDR stay untouched.
    for (int i = 0; i < 300; i++) begin
      set_idle();
      addr      = rand_addr();
      wdata     = 8'($urandom);
      cpu_write = ($urandom_range(0, 2) == 0) && (addr >= 16'h0020) && (addr != 16'h00FF);
      if ($urandom_range(0, 19) == 0) begin
        irq_sv = 1'b1; irq_sc = 16'($urandom_range(0, m_count + 12));
      end
      if ($urandom_range(0, 19) == 0) begin
        nmi_sv = 1'b1; nmi_sc = 16'($urandom_range(0, m_count + 12));
      end
      step("rand");
    end

    // Reset in the middle of RUN, right after a captured write.
    set_idle();
    addr = 16'hFFFB; cpu_write = 1'b1; wdata = 8'h77;
    step("pre_rst");
    cpu_write = 1'b0; nrst = 1'b0;
    step("mid_rst");
    check_reset_outputs("mid_rst");
    nrst = 1'b1;

    // Interrupt timing: IRQ at 5, NMI at 5 moved to 9 before it fires.
    addr = 16'h0010; irq_sv = 1'b1; irq_sc = 16'd5; nmi_sv = 1'b1; nmi_sc = 16'd5; #1;
    chk8("ram_kept_0010", d0_data, 8'h5A);
    step("intB");
    set_idle();
    addr = 16'h0001; go = 1'b1; #1;
    chk8("ram_kept_0001", d0_data, 8'h34);
    step("intB");
    for (int c = 0; c < 14; c++) begin
      set_idle();
      addr = rand_addr();
      if (c == 2) begin nmi_sv = 1'b1; nmi_sc = 16'd9; end
      #1;
      chk16("intB_count", d0_count, 16'(c));
      chk1 ("intB_irq", d0_irq, (c == 5) || (c == 6));
      chk1 ("intB_nmi", d0_nmi, (c == 9) || (c == 10));
      step("intB");
    end

    // Halt: past-target schedule, then a write to HALT_ADDR at cycle 7.
    set_idle(); nrst = 1'b0;
    step("rstC");
    nrst = 1'b1; go = 1'b1;
    step("goC");
    for (int c = 0; c < 8; c++) begin
      set_idle();
      addr = rand_addr();
      if (c == 4) begin irq_sv = 1'b1; irq_sc = 16'd3; end
      if (c == 7) begin addr = 16'h00FF; cpu_write = 1'b1; wdata = 8'h99; end
      #1;
      chk16("haltC_count", d0_count, 16'(c));
      chk1 ("past_target_irq", d0_irq, 1'b0);
      step("haltC");
    end
    set_idle();
    addr = 16'h0010; #1;
    chk1 ("halted", d0_halted, 1'b1);
    chk1 ("halt_cpu_nrst", d0_cpu_nrst, 1'b0);
    chk16("halt_count", d0_count, 16'd8);
    chk8 ("halt_read_0010", d0_data, 8'h5A);
    step("halt");
    for (int k = 0; k < 4; k++) begin
      addr = rand_addr(); #1;
      chk16("halt_count_frozen", d0_count, 16'd8);
      chk1 ("halt_irq", d0_irq, 1'b0);
      step("halt");
    end
    nrst = 1'b0;
    step("rstD");
    nrst = 1'b1; addr = 16'h00FF; #1;
    chk1("halt_exit_load_ready", d0_load_ready, 1'b1);
    chk1("halt_exit_halted", d0_halted, 1'b0);
    chk8("ram_kept_00ff", d0_data, 8'h99);
    step("post");
    addr = 16'h0001;
    step("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
